// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and registered, position-aligned outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAMECNT_EN.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = 10,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               pix_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               bright,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned H_VIS    = H_VISIBLE;
    localparam int unsigned V_VIS    = V_VISIBLE;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             adv;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_act;
    logic             vs_act;
    logic             bright_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= run && (div == DIV_LAST);
            if (run) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end
        end
    end

    assign adv = run && pix_tick;

    // Decode from the next position so outputs land in step with the counts
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        h_nxt      = h_wrap ? '0 : hcount + 1'b1;
        v_nxt      = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + 1'b1;
        end
        hs_act     = (32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END);
        vs_act     = (32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END);
        bright_nxt = (32'(h_nxt) < H_VIS) && (32'(v_nxt) < V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            bright      <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (adv) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            bright      <= bright_nxt;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (adv && h_wrap && v_wrap) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`else
    assign frame_count = '0;
`endif

endmodule
